// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiplies wait out a fixed latency; divides use a restoring divider, one quotient bit per cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);
  localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo, dvs, dvd;
  logic               b_zero, neg_q, neg_r;

  logic               accept, op_signed, is_mul, is_div, is_mthi, is_mtlo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_a, mul_b, product, first_step, next_step;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits. Returns {remainder, quotient/dividend}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {r, q[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d}) return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else                 return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  assign req_ready = (state == IDLE) & ~reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  assign op_signed = ~req_op[0];
  assign is_mul    = (req_op[2:1] == 2'b00);
  assign is_div    = (req_op[2:1] == 2'b01);
  assign is_mthi   = (req_op == 3'b100);
  assign is_mtlo   = (req_op == 3'b101);

  // Sign/zero-extending to 2*WIDTH makes the truncated product correct for both signednesses.
  assign mul_a   = op_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign mul_b   = op_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign product = mul_a * mul_b;

  assign a_mag = (op_signed & src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag = (op_signed & src_b[WIDTH-1]) ? -src_b : src_b;

  // The first quotient bit is produced on the accept edge so that WIDTH
  // iterations plus the sign-fix cycle finish in WIDTH+1 cycles.
  assign first_step = div_step('0, a_mag, b_mag);
  assign next_step  = div_step(rem, quo, dvs);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (is_mul) begin
              prod <= product;
              if (MUL_STAGES == 1) begin
                hi_out <= product[2*WIDTH-1:WIDTH];
                lo_out <= product[WIDTH-1:0];
                done   <= 1'b1;
              end else begin
                cnt   <= MUL_CNT;
                state <= MUL;
              end
            end else if (is_div) begin
              {rem, quo} <= first_step;
              dvs    <= b_mag;
              dvd    <= src_a;
              b_zero <= (src_b == '0);
              neg_q  <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              neg_r  <= op_signed & src_a[WIDTH-1];
              cnt    <= DIV_CNT;
              state  <= DIV;
            end else begin
              // MTHI/MTLO/NOP commit on the accept edge and never leave IDLE.
              if (is_mthi) hi_out <= src_a;
              if (is_mtlo) lo_out <= src_a;
              done <= 1'b1;
            end
          end
          MUL: begin
            if (cnt == '0) begin
              hi_out <= prod[2*WIDTH-1:WIDTH];
              lo_out <= prod[WIDTH-1:0];
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DIV: begin
            {rem, quo} <= next_step;
            if (cnt == CW'(1)) state <= FIX;
            else               cnt   <= cnt - 1'b1;
          end
          FIX: begin
            if (b_zero) begin
              lo_out <= '1;
              hi_out <= dvd;
            end else begin
              lo_out <= neg_q ? -quo : quo;
              hi_out <= neg_r ? -rem : rem;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level behavioural model checked every cycle,
// plus literal expectations for latencies and results.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'b111;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          flush = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural result and latency of one operation, from plain arithmetic.
  task automatic model_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] rh, output logic [W-1:0] rl,
                              output bit wh, output bit wl, output int n);
    logic [63:0] p;
    int sa, sb;
    rh = '0; rl = '0; wh = 0; wl = 0; n = 1;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin p = longint'(sa) * longint'(sb); {rh, rl} = p; wh = 1; wl = 1; n = 2; end
      3'b001: begin p = {32'b0, a} * {32'b0, b};     {rh, rl} = p; wh = 1; wl = 1; n = 2; end
      3'b010, 3'b011: begin
        wh = 1; wl = 1; n = W + 1;
        if (b == 0) begin rl = '1; rh = a; end
        else if (op == 3'b011) begin rl = a / b; rh = a % b; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = a; rh = 0; end
        else begin rl = sa / sb; rh = sa % sb; end
      end
      3'b100: begin rh = a; wh = 1; end
      3'b101: begin rl = a; wl = 1; end
      default: ;
    endcase
  endtask

  bit           m_started = 0, m_inflight = 0, m_done = 0;
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           p_wh = 0, p_wl = 0;

  always @(posedge clk) begin
    int n;
    m_done = 0;
    if (reset) begin
      m_inflight = 0; m_hi = '0; m_lo = '0;
    end else if (m_inflight) begin
      if (flush) m_inflight = 0;
      else if (m_left == 1) begin
        if (p_wh) m_hi = p_hi;
        if (p_wl) m_lo = p_lo;
        m_done = 1; m_inflight = 0;
      end else m_left--;
    end else if (req_valid && !flush) begin
      model_result(req_op, src_a, src_b, p_hi, p_lo, p_wh, p_wl, n);
      if (n == 1) begin
        if (p_wh) m_hi = p_hi;
        if (p_wl) m_lo = p_lo;
        m_done = 1;
      end else begin
        m_inflight = 1; m_left = n - 1;
      end
    end
    m_started = 1;
  end

  always @(negedge clk) if (m_started) begin
    chk("model_ready", 64'(req_ready), 64'(!m_inflight && !reset));
    chk("model_busy",  64'(busy),      64'(m_inflight));
    chk("model_done",  64'(done),      64'(m_done));
    chk("model_hi",    64'(hi_out),    64'(m_hi));
    chk("model_lo",    64'(lo_out),    64'(m_lo));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one op from an idle cycle, scramble operands after accept, wait for done.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input int en);
    int c;
    chk({name, "_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1; req_op = op; src_a = a; src_b = b;
    step();
    req_valid = 0; src_a = $urandom; src_b = $urandom;
    c = 1;
    while (done !== 1'b1 && c < 200) begin
      chk({name, "_busy"}, 64'({busy, req_ready}), 64'(2'b10));
      step();
      c++;
    end
    chk({name, "_latency"}, 64'(c), 64'(en));
    chk({name, "_hi"}, 64'(hi_out), 64'(ehi));
    chk({name, "_lo"}, 64'(lo_out), 64'(elo));
  endtask

  initial begin
    step();
    chk("reset_state", {hi_out, lo_out}, 64'(0));
    chk("reset_ctl", 64'({done, busy, req_ready}), 64'(0));
    step();
    reset = 0;
    step();

    do_op("mult",   3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2);
    do_op("multu",  3'b001, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 2);
    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
    do_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 2);
    do_op("divu",   3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    do_op("div_nq", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op("div_nd", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    do_op("div_nn", 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 33);
    do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    do_op("divu_big", 3'b011, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h5555_5555, 33);
    do_op("divu_z", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
    do_op("div_z",  3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
    do_op("mtlo",   3'b101, 32'h0, 32'h0, 32'd5, 32'h0, 1);
    do_op("mthi",   3'b100, 32'h1234, 32'h0, 32'h1234, 32'h0, 1);
    do_op("nop",    3'b110, 32'hDEAD, 32'hBEEF, 32'h1234, 32'h0, 1);

    // Divide aborted by flush in cycle 10, then MTLO in cycle 11.
    req_valid = 1; req_op = 3'b010; src_a = 32'd100; src_b = 32'd7;
    step();
    req_valid = 0;
    for (int k = 1; k < 10; k++) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_state", 64'({done, req_ready}), 64'(2'b01));
    chk("flush_hi", 64'(hi_out), 64'(32'h1234));
    req_valid = 1; req_op = 3'b101; src_a = 32'h55;
    step();
    req_valid = 0;
    chk("flush_mtlo", {31'b0, done, lo_out}, {31'b0, 1'b1, 32'h55});

    // Flush on the commit edge of a multiply.
    req_valid = 1; req_op = 3'b000; src_a = 32'd3; src_b = 32'd4;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("flush_commit", {done, busy, req_ready, 29'b0, lo_out}, {3'b001, 29'b0, 32'h55});

    // Flush alongside a request in IDLE discards it.
    req_valid = 1; flush = 1;
    step();
    req_valid = 0; flush = 0;
    chk("flush_idle_req", 64'({busy, req_ready}), 64'(2'b01));
    step();
    chk("flush_idle_nodone", 64'(done), 64'(0));

    // Held req_valid: MULT, MULT, DIVU accepted in cycles 0, 2, 4; reset in cycle 6.
    req_valid = 1; req_op = 3'b000; src_a = 32'd3; src_b = 32'd4;
    step();
    chk("b2b_c1", 64'({done, req_ready}), 64'(2'b00));
    step();
    chk("b2b_c2", {31'b0, done, lo_out}, {31'b0, 1'b1, 32'd12});
    src_a = 32'd5; src_b = 32'd6;
    step();
    step();
    chk("b2b_c4", {31'b0, done, lo_out}, {31'b0, 1'b1, 32'd30});
    req_op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    step();
    req_valid = 0;
    chk("b2b_c5", 64'(busy), 64'(1));
    step();
    reset = 1;
    step();
    chk("mid_reset_regs", {hi_out, lo_out}, 64'(0));
    chk("mid_reset_ctl", 64'({done, busy, req_ready}), 64'(0));
    reset = 0;
    step();
    step();
    chk("post_reset_ready", 64'(req_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
